edac_secded_pipe: RTL

- Parametrised, pipelined SEC-DED Hamming codec. Next generation of the 32-bit combinational EDAC.
- Provides:
  - a registered encode path;
  - a 2-stage decode/correct path with valid/ready backpressure;
  - saturating error counters;
  - first-error syndrome capture.
- Sits between the memory controller and SRAM arrays. Data width is selectable per instance.

---
 rtl/edac_pkg.sv | 62 ++++++
 rtl/edac_secded_enc.sv | 15 +
 rtl/edac_secded_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/edac_pkg.sv
// Shared definitions for the SEC-DED codec.
// - calc_p:   number of Hamming check bits P for a given data width.
// - is_pow2:  true for 1, 2, 4, ...
// - pos_of:   codeword position (1-based) of data bit k.
// - calc_chk: raw check bits {overall parity, chk[P-1:0]} for a data word.
// - edac_class_e: decode classification.
package edac_pkg;

  localparam int unsigned MaxDataW = 64;
  localparam int unsigned MaxChkW  = 8;

  typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE, UNCORR} edac_class_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 7;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Data bit k lands on the k-th position that is not a power of two.
  function automatic int pos_of(input int k);
    int pos;
    pos = 2;
    for (int j = 0; j < MaxDataW; j++) begin
      if (j <= k) begin
        pos++;
        if (is_pow2(pos)) pos++;
      end
    end
    return pos;
  endfunction

  // Bits of data above data_w must be zero.
  function automatic logic [MaxChkW-1:0] calc_chk(input logic [MaxDataW-1:0] data,
                                                  input int data_w, input int p);
    logic [MaxChkW-1:0] chk;
    int pos;
    chk = '0;
    pos = 2;
    for (int k = 0; k < MaxDataW; k++) begin
      if (k < data_w) begin
        pos++;
        if (is_pow2(pos)) pos++;
        for (int i = 0; i < MaxChkW - 1; i++) begin
          if (i < p && ((pos >> i) & 1) == 1 && data[k[5:0]]) chk[i[2:0]] = ~chk[i[2:0]];
        end
      end
    end
    // Overall parity covers data plus the Hamming bits.
    chk = chk | (MaxChkW'(^data ^ ^chk) << p);
    return chk;
  endfunction

endpackage

// File: rtl/edac_secded_enc.sv
// Combinational SEC-DED check-bit generator (raw, no inversion mask).
// Ports:
//   data  in   DATA_W  data word
//   chk   out  CHK_W   {overall parity, Hamming check bits}
module edac_secded_enc import edac_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = calc_p(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] data,
  output logic [CHK_W-1:0]  chk
);

  assign chk = CHK_W'(calc_chk(MaxDataW'(data), DATA_W, CHK_W - 1));

endmodule

// File: rtl/edac_secded_pipe.sv
// Pipelined SEC-DED Hamming codec.
// Encode: registered, latency 1. Decode: 2 stages with valid/ready backpressure,
// saturating error counters and first-error syndrome capture.
// Ports:
//   clk, rst                           clock, async active-high reset
//   enc_valid/enc_data                 encode request
//   enc_out_valid/enc_out_data/enc_check  encode result (check bits masked)
//   in_valid/in_ready/in_data/in_check decode request from memory
//   out_valid/out_ready/out_data       corrected decode result
//   out_single/out_double/out_uncorr   decode status
//   cnt_clr                            sync clear of counters and capture
//   cnt_single/cnt_uncorr              saturating handshake counters
//   err_capt_valid/err_capt_syn        first captured {parity flag, syndrome}
module edac_secded_pipe import edac_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int P     = calc_p(DATA_W),
  localparam int CHK_W = P + 1,
  parameter logic [CHK_W-1:0] INV_MASK = CHK_W'('h0C)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_valid,
  input  logic [DATA_W-1:0] enc_data,
  output logic              enc_out_valid,
  output logic [DATA_W-1:0] enc_out_data,
  output logic [CHK_W-1:0]  enc_check,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_uncorr,
  output logic              err_capt_valid,
  output logic [CHK_W-1:0]  err_capt_syn
);

  // ---------------- Encode path ----------------
  logic [CHK_W-1:0]  enc_chk_raw;
  logic              enc_valid_q;
  logic [DATA_W-1:0] enc_data_q;
  logic [CHK_W-1:0]  enc_check_q;

  edac_secded_enc #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_enc (
    .data (enc_data),
    .chk  (enc_chk_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      enc_check_q <= '0;
    end else begin
      enc_valid_q <= enc_valid;
      if (enc_valid) begin
        enc_data_q  <= enc_data;
        enc_check_q <= enc_chk_raw ^ INV_MASK;
      end
    end
  end

  assign enc_out_valid = enc_valid_q;
  assign enc_out_data  = enc_data_q;
  assign enc_check     = enc_check_q;

  // ---------------- Decode stage 1: syndrome ----------------
  logic [CHK_W-1:0] dec_c;
  logic [CHK_W-1:0] dec_rchk;
  logic [P-1:0]     dec_syn;
  logic             dec_par;
  logic             advance;

  assign dec_c = in_check ^ INV_MASK;

  edac_secded_enc #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_dec_enc (
    .data (in_data),
    .chk  (dec_rchk)
  );

  assign dec_syn = dec_c[P-1:0] ^ dec_rchk[P-1:0];
  // Equals ^in_data ^ ^dec_c: dec_rchk[P] already folds ^in_data with ^dec_rchk[P-1:0].
  assign dec_par = dec_rchk[P] ^ dec_c[P] ^ (^dec_syn);

  logic              out_valid_q;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [P-1:0]      s1_syn_q;
  logic              s1_par_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_data_q  <= in_data;
      s1_syn_q   <= dec_syn;
      s1_par_q   <= dec_par;
    end
  end

  // ---------------- Decode stage 2: classify / correct ----------------
  edac_class_e       cls;
  logic [DATA_W-1:0] flip;
  logic [DATA_W-1:0] corr_data;

  always_comb begin
    cls = CLEAN;
    if (s1_par_q) begin
      if (int'(s1_syn_q) > DATA_W + P) cls = UNCORR;
      else                             cls = SINGLE;
    end else if (s1_syn_q != '0) begin
      cls = DOUBLE;
    end
  end

  // Syndromes of 0, powers of two and out-of-range values match no data position.
  for (genvar k = 0; k < DATA_W; k++) begin : g_flip
    assign flip[k] = (int'(s1_syn_q) == pos_of(k));
  end

  assign corr_data = s1_par_q ? (s1_data_q ^ flip) : s1_data_q;

  logic [DATA_W-1:0] out_data_q;
  logic              out_single_q, out_double_q, out_uncorr_q;
  logic [CHK_W-1:0]  out_syn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      out_uncorr_q <= 1'b0;
      out_syn_q    <= '0;
    end else if (advance) begin
      out_valid_q  <= s1_valid_q;
      out_data_q   <= corr_data;
      out_single_q <= s1_valid_q && (cls == SINGLE);
      out_double_q <= s1_valid_q && (cls == DOUBLE);
      out_uncorr_q <= s1_valid_q && ((cls == DOUBLE) || (cls == UNCORR));
      out_syn_q    <= {s1_par_q, s1_syn_q};
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_single = out_single_q;
  assign out_double = out_double_q;
  assign out_uncorr = out_uncorr_q;

  // ---------------- Counters and capture ----------------
  logic             hs, inc_single, inc_uncorr, capt_err;
  logic [CNT_W-1:0] cnt_single_d, cnt_single_q, cnt_uncorr_d, cnt_uncorr_q;
  logic             capt_valid_d, capt_valid_q;
  logic [CHK_W-1:0] capt_syn_d, capt_syn_q;

  assign hs         = out_valid_q && out_ready;
  assign inc_single = hs && out_single_q;
  assign inc_uncorr = hs && out_uncorr_q;
  assign capt_err   = hs && (out_single_q || out_uncorr_q);

  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_uncorr_d = cnt_uncorr_q;
    capt_valid_d = capt_valid_q;
    capt_syn_d   = capt_syn_q;
    if (cnt_clr) begin
      // A coinciding event survives the clear.
      cnt_single_d = inc_single ? CNT_W'(1) : '0;
      cnt_uncorr_d = inc_uncorr ? CNT_W'(1) : '0;
      capt_valid_d = capt_err;
      capt_syn_d   = capt_err ? out_syn_q : '0;
    end else begin
      if (inc_single && cnt_single_q != '1) cnt_single_d = cnt_single_q + 1'b1;
      if (inc_uncorr && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + 1'b1;
      if (capt_err && !capt_valid_q) begin
        capt_valid_d = 1'b1;
        capt_syn_d   = out_syn_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_single_q <= '0;
      cnt_uncorr_q <= '0;
      capt_valid_q <= 1'b0;
      capt_syn_q   <= '0;
    end else begin
      cnt_single_q <= cnt_single_d;
      cnt_uncorr_q <= cnt_uncorr_d;
      capt_valid_q <= capt_valid_d;
      capt_syn_q   <= capt_syn_d;
    end
  end

  assign cnt_single     = cnt_single_q;
  assign cnt_uncorr     = cnt_uncorr_q;
  assign err_capt_valid = capt_valid_q;
  assign err_capt_syn   = capt_syn_q;

endmodule
